// File: rtl/fifo_drain_if.sv
// Handshake bundle between the FIFO controller, the drain engine and the downstream consumer.
// The master view belongs to the drain engine; the slave view belongs to its surroundings.
interface fifo_drain_if #(
   parameter int DW = 16
);
   logic          empty;
   logic          fifo_err;
   logic [DW-1:0] fifo_dout;
   logic          pop;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;

   modport master (
      input  empty, fifo_err, fifo_dout, out_ready,
      output pop, out_valid, out_data
   );

   modport slave (
      output empty, fifo_err, fifo_dout, out_ready,
      input  pop, out_valid, out_data
   );
endinterface

// File: rtl/fifo_drain.sv
// Drains a FIFO one word every three cycles into a 2-entry skid queue feeding a valid/ready consumer,
// counting accepted words and latching any FIFO error.
module fifo_drain #(
   parameter int DW = 16,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   fifo_drain_if.master  bus,
   output logic [CW-1:0] drained,
   output logic          err_seen
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      POP     = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   state_t        state;
   logic [DW-1:0] buf_q [2];
   logic          rd_ptr;
   logic          wr_ptr;
   logic [1:0]    occ;
   logic          capture;
   logic          xfer;

   assign capture = (state == CAPTURE);
   assign xfer    = bus.out_valid && bus.out_ready;

   // Only IDLE can launch a pop, and at that point no word is in flight, so occ<2 leaves room for it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE:    if (!bus.empty && occ < 2'd2) state <= POP;
            POP:     state <= CAPTURE;
            CAPTURE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.pop = (state == POP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the storage is reset on purpose: out_data reads the rd entry directly and must show 0 in reset.
         buf_q[0] <= '0;
         buf_q[1] <= '0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         occ      <= 2'd0;
         drained  <= '0;
      end else begin
         if (capture) begin
            buf_q[wr_ptr] <= bus.fifo_dout;
            wr_ptr        <= ~wr_ptr;
         end
         if (xfer) begin
            rd_ptr  <= ~rd_ptr;
            drained <= drained + CW'(1);
         end
         unique case ({capture, xfer})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_seen <= 1'b0;
      end else if (bus.fifo_err) begin
         err_seen <= 1'b1;
      end
   end

   assign bus.out_valid = (occ != 2'd0);
   assign bus.out_data  = buf_q[rd_ptr];

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain: a small array-backed FIFO feeds the DUT and each step checks
// hand-computed pop/valid/data/count values.
module tb_fifo_drain;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] drained;
   logic        err_seen;
   logic        prev_pop = 1'b0;

   fifo_drain_if #(.DW(16)) bus();

   fifo_drain #(.DW(16), .CW(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .drained  (drained),
      .err_seen (err_seen)
   );

   always #5 clk = ~clk;

   // FIFO model: read data appears the cycle after a pop.
   logic [15:0] mem [16];
   int          head = 0;
   int          tail = 0;

   assign bus.empty = (head == tail);

   always @(posedge clk) begin
      if (bus.pop) begin
         bus.fifo_dout <= mem[head];
         head          <= head + 1;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [15:0] w);
      mem[tail] = w;
      tail      = tail + 1;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Running protocol checks: never pop an empty FIFO, never hold pop for two cycles.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("pop_while_empty", {31'b0, bus.pop & bus.empty}, 32'd0);
         chk("pop_width", {31'b0, prev_pop & bus.pop}, 32'd0);
      end
      prev_pop = bus.pop;
   end

   initial begin
      logic exp_v;
      logic exp_p;
      logic [15:0] exp_d;

      bus.out_ready = 1'b0;
      bus.fifo_err  = 1'b0;
      rst_n         = 1'b0;
      repeat (2) tick();

      chk("rst_pop",       {31'b0, bus.pop},       32'd0);
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_out_data",  {16'b0, bus.out_data},  32'd0);
      chk("rst_drained",   {16'b0, drained},       32'd0);
      chk("rst_err_seen",  {31'b0, err_seen},      32'd0);

      // Empty FIFO for 20 cycles: nothing moves.
      rst_n = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         chk("empty_pop",   {31'b0, bus.pop},       32'd0);
         chk("empty_valid", {31'b0, bus.out_valid}, 32'd0);
      end
      chk("empty_err_seen", {31'b0, err_seen}, 32'd0);

      // Three words with the consumer always ready: pops at 1,4,7 and words at 3,6,9.
      bus.out_ready = 1'b1;
      push(16'h0001);
      push(16'h0002);
      push(16'h0003);
      for (int k = 1; k <= 12; k++) begin
         tick();
         exp_p = (k == 1 || k == 4 || k == 7);
         exp_v = (k == 3 || k == 6 || k == 9);
         chk("drain_pop",   {31'b0, bus.pop},       {31'b0, exp_p});
         chk("drain_valid", {31'b0, bus.out_valid}, {31'b0, exp_v});
         if (exp_v) chk("drain_data", {16'b0, bus.out_data}, k / 3);
      end
      chk("drain_count", {16'b0, drained}, 32'd3);

      // Backpressure with four words: two pops fill the queue, then the engine stalls.
      bus.out_ready = 1'b0;
      push(16'h00A1);
      push(16'h00A2);
      push(16'h00A3);
      push(16'h00A4);
      for (int k = 1; k <= 12; k++) begin
         tick();
         exp_p = (k == 1 || k == 4);
         chk("bp_pop",   {31'b0, bus.pop},       {31'b0, exp_p});
         chk("bp_valid", {31'b0, bus.out_valid}, {31'b0, (k >= 3)});
         if (k >= 3) chk("bp_data_hold", {16'b0, bus.out_data}, 32'h00A1);
      end
      chk("bp_occ",     {30'b0, dut.occ}, 32'd2);
      chk("bp_drained", {16'b0, drained}, 32'd3);

      // Release backpressure: A1,A2 leave back to back, then A3,A4 follow the 3-cycle pop cadence.
      bus.out_ready = 1'b1;
      chk("rel_valid0", {31'b0, bus.out_valid}, 32'd1);
      chk("rel_data0",  {16'b0, bus.out_data},  32'h00A1);
      for (int k = 1; k <= 9; k++) begin
         tick();
         exp_v = (k == 1 || k == 4 || k == 7);
         exp_p = (k == 2 || k == 5);
         exp_d = (k == 1) ? 16'h00A2 : (k == 4) ? 16'h00A3 : 16'h00A4;
         chk("rel_pop",   {31'b0, bus.pop},       {31'b0, exp_p});
         chk("rel_valid", {31'b0, bus.out_valid}, {31'b0, exp_v});
         if (exp_v) chk("rel_data", {16'b0, bus.out_data}, {16'b0, exp_d});
      end
      chk("rel_drained", {16'b0, drained}, 32'd7);

      // Consumer becomes ready during CAPTURE with one word buffered: occupancy stays at 1.
      bus.out_ready = 1'b0;
      push(16'h00B1);
      push(16'h00B2);
      repeat (5) tick();
      chk("same_state", {30'b0, dut.state},    32'd2);
      chk("same_occ0",  {30'b0, dut.occ},      32'd1);
      chk("same_data0", {16'b0, bus.out_data}, 32'h00B1);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("same_valid",   {31'b0, bus.out_valid}, 32'd1);
      chk("same_data1",   {16'b0, bus.out_data},  32'h00B2);
      chk("same_occ1",    {30'b0, dut.occ},       32'd1);
      chk("same_drained", {16'b0, drained},       32'd8);
      tick();
      chk("same_hold", {16'b0, bus.out_data}, 32'h00B2);

      // One-cycle error pulse latches err_seen.
      bus.fifo_err = 1'b1;
      chk("err_before", {31'b0, err_seen}, 32'd0);
      tick();
      bus.fifo_err = 1'b0;
      chk("err_set", {31'b0, err_seen}, 32'd1);
      repeat (5) tick();
      chk("err_sticky", {31'b0, err_seen}, 32'd1);

      // Reset during CAPTURE: every output clears at once and the in-flight word is lost.
      push(16'h00D1);
      tick();
      chk("rc_pop", {31'b0, bus.pop}, 32'd1);
      tick();
      chk("rc_state", {30'b0, dut.state},    32'd2);
      chk("rc_data",  {16'b0, bus.out_data}, 32'h00B2);
      rst_n = 1'b0;
      #1;
      chk("rc_pop0",      {31'b0, bus.pop},       32'd0);
      chk("rc_valid0",    {31'b0, bus.out_valid}, 32'd0);
      chk("rc_data0",     {16'b0, bus.out_data},  32'd0);
      chk("rc_drained0",  {16'b0, drained},       32'd0);
      chk("rc_err_seen0", {31'b0, err_seen},      32'd0);
      chk("rc_state0",    {30'b0, dut.state},     32'd0);
      chk("rc_occ0",      {30'b0, dut.occ},       32'd0);
      push(16'h00D3);
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      chk("rel_no_pop", {31'b0, bus.pop}, 32'd0);
      tick();
      chk("rel_first_pop", {31'b0, bus.pop}, 32'd1);
      tick();
      tick();
      chk("rel_valid_d3", {31'b0, bus.out_valid}, 32'd1);
      chk("rel_data_d3",  {16'b0, bus.out_data},  32'h00D3);
      chk("rel_drained0", {16'b0, drained},       32'd0);
      chk("rel_err0",     {31'b0, err_seen},      32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
